// File: rtl/uart_report_tx.sv
// ---------------------------------------------------------------------------
// uart_report_tx
// Formats the counter value as an ASCII frame and writes it byte-by-byte into
// the UART TX FIFO. A frame is: [echo char] DIGITS decimal digits, CR, LF.
// The conversion uses an iterative shift-add-3 (double dabble), one bit per
// clock, so the first byte appears CNT_W+1 cycles after the request.
//
// Optional build macro: UART_REPORT_LZ_BLANK_EN
//   defined   -> leading zero digits are sent as spaces (0x20); the least
//                significant digit is always a numeral.
//   undefined -> every digit is sent as a numeral, leading zeros included.
// ---------------------------------------------------------------------------
module uart_report_tx #(
    parameter int DATALEN = 8,
    parameter int CNT_W   = 14,
    parameter int DIGITS  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               report_req,
    input  logic               evt_valid,
    input  logic [2:0]         evt_code,
    input  logic [CNT_W-1:0]   cnt_value,
    input  logic               fifo_full,
    output logic               fifo_wr,
    output logic [DATALEN-1:0] fifo_wdata,
    output logic               busy,
    output logic               drop
);

    localparam int          BCD_W    = 4 * DIGITS;
    localparam int          LAST_IDX = DIGITS + 2;            // index of the LF byte
    localparam int          IDX_W    = $clog2(DIGITS + 3);
    localparam int          NCHR     = 1 << IDX_W;
    localparam int          CC_W     = $clog2(CNT_W + 1);
    localparam int unsigned MAX_VAL  = (10 ** DIGITS) - 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_bin;        // binary value being shifted out MSB first
    logic [BCD_W-1:0] r_bcd;        // BCD accumulator, digit 0 in the low nibble
    logic [CC_W-1:0]  r_cnt;        // conversion bit counter
    logic [IDX_W-1:0] r_idx;        // frame byte index: 0=echo, 1..DIGITS, CR, LF
    logic [7:0]       r_echo_chr;
    logic             r_drop;

    logic [CNT_W-1:0] w_sat_val;
    logic [BCD_W-1:0] w_bcd_adj;
    logic [7:0]       w_chr [0:NCHR-1];
    logic [7:0]       w_cur;
    logic [3:0]       w_dig;
    logic             w_lead;
    logic             w_wr;

    // Map the executed one-hot command to the character echoed in the frame.
    function automatic logic [7:0] echo_char(input logic [2:0] code);
        logic [7:0] chr;
        case (code)
            3'b100:  chr = 8'h6D;   // 'm'
            3'b010:  chr = 8'h63;   // 'c'
            3'b001:  chr = 8'h72;   // 'r'
            default: chr = 8'h3F;   // '?'
        endcase
        return chr;
    endfunction

    // Clamp values that do not fit in DIGITS decimal digits to all nines.
    always_comb begin
        if (32'(cnt_value) > MAX_VAL) begin
            w_sat_val = CNT_W'(MAX_VAL);
        end else begin
            w_sat_val = cnt_value;
        end
    end

    // Double-dabble correction: add 3 to every BCD digit that is 5 or more.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_bcd[4*k +: 4] >= 4'd5) begin
                w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
            end else begin
                w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4];
            end
        end
    end

    // Build the character table for the frame and pick the current byte.
    always_comb begin
        for (int j = 0; j < NCHR; j++) begin
            w_chr[j] = 8'h00;
        end
        w_dig    = 4'd0;
        w_lead   = 1'b1;
        w_chr[0] = r_echo_chr;
        for (int k = 0; k < DIGITS; k++) begin
            w_dig = r_bcd[4*(DIGITS-1-k) +: 4];
            if (w_dig != 4'd0) begin
                w_lead = 1'b0;
            end else begin
                w_lead = w_lead;
            end
`ifdef UART_REPORT_LZ_BLANK_EN
            if (w_lead && (k != DIGITS - 1)) begin
                w_chr[k+1] = 8'h20;
            end else begin
                w_chr[k+1] = {4'h3, w_dig};
            end
`else
            w_chr[k+1] = {4'h3, w_dig};
`endif
        end
        w_chr[DIGITS+1] = 8'h0D;
        w_chr[DIGITS+2] = 8'h0A;
        w_cur = w_chr[r_idx];
    end

    // FIFO write port: write whenever sending and the FIFO has room.
    assign w_wr       = (r_state == ST_SEND) && !fifo_full;
    assign fifo_wr    = w_wr;
    assign fifo_wdata = (r_state == ST_SEND) ? DATALEN'(w_cur) : '0;
    assign busy       = (r_state != ST_IDLE);
    assign drop       = r_drop;

    // Frame sequencer: accept request, convert to BCD, stream the frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_bin      <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_echo_chr <= 8'h00;
            r_drop     <= 1'b0;
        end else begin
            r_drop <= (r_state != ST_IDLE) && (report_req || evt_valid);
            case (r_state)
                ST_IDLE: begin
                    if (report_req || evt_valid) begin
                        r_bin   <= w_sat_val;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                        r_state <= ST_CONV;
                        if (evt_valid) begin
                            r_echo_chr <= echo_char(evt_code);
                            r_idx      <= '0;
                        end else begin
                            r_echo_chr <= 8'h00;
                            r_idx      <= IDX_W'(1);   // skip the echo slot
                        end
                    end
                end
                ST_CONV: begin
                    r_bcd <= {w_bcd_adj[BCD_W-2:0], r_bin[CNT_W-1]};
                    r_bin <= {r_bin[CNT_W-2:0], 1'b0};
                    r_cnt <= r_cnt + CC_W'(1);
                    if (r_cnt == CC_W'(CNT_W - 1)) begin
                        r_state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (w_wr) begin
                        if (r_idx == IDX_W'(LAST_IDX)) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_report_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_report_tx
// Scoreboard bench: each accepted request pushes its expected frame bytes,
// computed arithmetically from the value, into a queue; a monitor pops and
// compares on every FIFO write, and also flags missing writes, early writes,
// writes while full and unexpected drop pulses.
// ---------------------------------------------------------------------------
module tb_uart_report_tx;

    localparam int DATALEN = 8;
    localparam int CNT_W   = 14;
    localparam int DIGITS  = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               report_req = 1'b0;
    logic               evt_valid = 1'b0;
    logic [2:0]         evt_code = 3'b000;
    logic [CNT_W-1:0]   cnt_value = '0;
    logic               fifo_full = 1'b0;
    logic               fifo_wr;
    logic [DATALEN-1:0] fifo_wdata;
    logic               busy;
    logic               drop;

    typedef struct {
        logic [7:0] b;
        longint     min_cyc;
        bit         last;
    } exp_t;

    exp_t   exp_q[$];
    longint drop_q[$];
    longint cyc = 0;
    int     n_cmp = 0;
    int     n_fail = 0;
    int     n_wr = 0;
    int     n_acc = 0;
    int     n_done = 0;
    bit     bp_en = 1'b0;

    uart_report_tx #(.DATALEN(DATALEN), .CNT_W(CNT_W), .DIGITS(DIGITS)) dut (
        .clk        (clk),
        .rst        (rst),
        .report_req (report_req),
        .evt_valid  (evt_valid),
        .evt_code   (evt_code),
        .cnt_value  (cnt_value),
        .fifo_full  (fifo_full),
        .fifo_wr    (fifo_wr),
        .fifo_wdata (fifo_wdata),
        .busy       (busy),
        .drop       (drop)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    function automatic void check(input string nm, input longint act, input longint expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
        end
    endfunction

    function automatic bit model_busy();
        return n_acc != n_done;
    endfunction

    // Reference frame: echo char, decimal digits of the clamped value, CR LF.
    function automatic void push_frame(input bit echo, input logic [2:0] code,
                                       input int unsigned val, input longint c);
        int unsigned maxv;
        int unsigned v;
        int unsigned p;
        int          d;
        bit          lead;
        bit          first;
        exp_t        e;
        maxv  = (10 ** DIGITS) - 1;
        v     = (val > maxv) ? maxv : val;
        first = 1'b1;
        e.last = 1'b0;
        if (echo) begin
            if (code == 3'b100)      e.b = "m";
            else if (code == 3'b010) e.b = "c";
            else if (code == 3'b001) e.b = "r";
            else                     e.b = "?";
            e.min_cyc = c + CNT_W + 1;
            first = 1'b0;
            exp_q.push_back(e);
        end
        lead = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            p = 10 ** (DIGITS - 1 - i);
            d = int'((v / p) % 10);
            if (d != 0) lead = 1'b0;
            e.b = 8'(48 + d);
`ifdef UART_REPORT_LZ_BLANK_EN
            if (lead && (i != DIGITS - 1)) e.b = 8'h20;
`endif
            e.min_cyc = first ? (c + CNT_W + 1) : 0;
            first = 1'b0;
            exp_q.push_back(e);
        end
        e.b = 8'h0D; e.min_cyc = 0;
        exp_q.push_back(e);
        e.b = 8'h0A; e.last = 1'b1;
        exp_q.push_back(e);
    endfunction

    // Monitor: compare every write, catch missing/early writes and drop pulses.
    initial begin
        exp_t e;
        bit   dexp;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (fifo_wr && fifo_full) check("wr_while_full", 1, 0);
                if (fifo_wr) begin
                    n_wr++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_write", longint'(fifo_wdata), -1);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame_byte", longint'(fifo_wdata), longint'(e.b));
                        if (cyc < e.min_cyc) check("early_write_cycle", cyc, e.min_cyc);
                        if (e.last) n_done++;
                    end
                end else if (exp_q.size() != 0 && cyc >= exp_q[0].min_cyc && !fifo_full) begin
                    check("missing_write", 0, 1);
                end
                while (drop_q.size() != 0 && drop_q[0] < cyc) void'(drop_q.pop_front());
                dexp = (drop_q.size() != 0 && drop_q[0] == cyc);
                if (dexp) void'(drop_q.pop_front());
                if (drop || dexp) check("drop", longint'(drop), longint'(dexp));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (bp_en) fifo_full = ($urandom_range(3) == 0);
    endtask

    task automatic tick(input int n);
        repeat (n) step();
    endtask

    // Drive a one-cycle request and record its expected outcome.
    task automatic issue(input bit rep, input bit ev, input logic [2:0] code,
                         input logic [CNT_W-1:0] val);
        report_req = rep;
        evt_valid  = ev;
        evt_code   = code;
        cnt_value  = val;
        if (rep || ev) begin
            if (model_busy()) begin
                drop_q.push_back(cyc + 1);
            end else begin
                push_frame(ev, code, int'(val), cyc);
                n_acc++;
            end
        end
        step();
        report_req = 1'b0;
        evt_valid  = 1'b0;
        evt_code   = 3'($urandom);
        cnt_value  = CNT_W'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        drop_q.delete();
        n_acc = n_done;
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while (model_busy() && i < 400) begin
            step();
            i++;
        end
        check("frame_timeout", longint'(model_busy()), 0);
        if (model_busy()) do_reset();
    endtask

    task automatic rand_req();
        int          k;
        int          s;
        logic [CNT_W-1:0] v;
        k = $urandom_range(2);
        s = $urandom_range(5);
        case (s)
            0:       v = '0;
            1:       v = CNT_W'(9999);
            2:       v = CNT_W'(10000);
            3:       v = '1;
            default: v = CNT_W'($urandom);
        endcase
        issue(k != 1, k != 0, 3'($urandom), v);
    endtask

    initial begin
        int base;
        int g;
        tick(3);
        check("rst_fifo_wr", longint'(fifo_wr), 0);
        check("rst_fifo_wdata", longint'(fifo_wdata), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_drop", longint'(drop), 0);
        rst = 1'b0;
        step();

        // value-only frame, then busy must fall after the LF
        issue(1'b1, 1'b0, 3'b000, CNT_W'(1234));
        check("busy_in_conv", longint'(busy), 1);
        wait_idle();
        step();
        check("busy_after_frame", longint'(busy), 0);
        check("wdata_idle", longint'(fifo_wdata), 0);

        // echo frame, all-zero value
        issue(1'b0, 1'b1, 3'b010, CNT_W'(0));
        wait_idle();

        // saturation and the largest representable value
        issue(1'b1, 1'b0, 3'b000, CNT_W'(12000));
        wait_idle();
        issue(1'b1, 1'b0, 3'b000, CNT_W'(9999));
        wait_idle();

        // backpressure after the second byte
        base = n_wr;
        issue(1'b1, 1'b0, 3'b000, CNT_W'(1234));
        g = 0;
        while (n_wr < base + 2 && g < 100) begin step(); g++; end
        fifo_full = 1'b1;
        tick(5);
        fifo_full = 1'b0;
        wait_idle();
        check("bp_write_count", n_wr - base, 6);

        // request while busy is dropped; then back-to-back simultaneous request
        issue(1'b1, 1'b0, 3'b000, CNT_W'(4321));
        tick(4);
        issue(1'b1, 1'b0, 3'b000, CNT_W'(7));
        wait_idle();
        issue(1'b1, 1'b1, 3'b100, CNT_W'(55));
        wait_idle();
        tick(20);

        // reset after the third byte, then a fresh frame
        base = n_wr;
        issue(1'b0, 1'b1, 3'b001, CNT_W'(678));
        g = 0;
        while (n_wr < base + 3 && g < 100) begin step(); g++; end
        do_reset();
        check("post_rst_fifo_wr", longint'(fifo_wr), 0);
        check("post_rst_busy", longint'(busy), 0);
        issue(1'b1, 1'b0, 3'b000, CNT_W'(2468));
        wait_idle();

        // randomized traffic with backpressure and requests while busy
        bp_en = 1'b1;
        for (int it = 0; it < 120; it++) begin
            rand_req();
            g = 0;
            while (model_busy() && g < 400) begin
                if ($urandom_range(15) == 0) rand_req();
                else step();
                g++;
            end
            wait_idle();
            tick($urandom_range(3));
        end
        bp_en = 1'b0;
        fifo_full = 1'b0;
        wait_idle();
        tick(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
